// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search helper for the AXIS packet arbiter.
// Supports request vectors of up to MaxReq bits.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StPass
    } arb_state_e;

    localparam int unsigned MaxReq = 32;

    // Returns the first asserted request after `last` (wrapping modulo n); `last` is checked last.
    // If nothing is requested, `last` is returned unchanged.
    function automatic int unsigned rr_pick(logic [MaxReq-1:0] req, int unsigned last,
                                            int unsigned n);
        int unsigned idx;
        rr_pick = last;
        // Walk the search order backwards so the earliest hit is the one left standing.
        for (int off = int'(n); off > 0; off--) begin
            idx = (last + unsigned'(off)) % n;
            if ((req & (MaxReq'(1) << idx)) != '0) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin select: next requester after last_i, wrapping, last_i lowest priority.
module rr_priority_select
    import axis_arb_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    localparam int unsigned IdxW  = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    always_comb begin
        idx_o   = IdxW'(rr_pick(MaxReq'(req_i), 32'(last_i), NumReq));
        valid_o = |req_i;
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin AXIS arbiter; grant held from first beat through tlast.
// Define AXIS_PACKET_ARBITER_ID_EN to add the axis_o_id output (current grant index).
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_INPUTS     = 4,
    parameter int unsigned AXIS_BYTES     = 1,
    parameter int unsigned AXIS_USER_BITS = 1
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [NUM_INPUTS*8*AXIS_BYTES-1:0]   axis_i_tdata,
    input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0] axis_i_tuser,
    input  logic [NUM_INPUTS-1:0]                axis_i_tlast,
    input  logic [NUM_INPUTS-1:0]                axis_i_tvalid,
    output logic [NUM_INPUTS-1:0]                axis_i_tready,
    output logic [8*AXIS_BYTES-1:0]              axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
    output logic                                 axis_o_tlast,
    output logic                                 axis_o_tvalid,
    input  logic                                 axis_o_tready
`ifdef AXIS_PACKET_ARBITER_ID_EN
    ,
    output logic [$clog2(NUM_INPUTS)-1:0]        axis_o_id
`endif
);

    localparam int unsigned DataW = 8 * AXIS_BYTES;
    localparam int unsigned IdxW  = $clog2(NUM_INPUTS);

    arb_state_e            state_q;
    logic [IdxW-1:0]       grant_q;
    logic [NUM_INPUTS-1:0] grant_oh;
    logic [NUM_INPUTS-1:0] req;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_valid;
    logic                  pass;
    logic                  pkt_done;
    int                    sel;

    assign pass     = (state_q == StPass);
    assign grant_oh = NUM_INPUTS'(1) << grant_q;
    // The finishing source's current beat is already consumed, so it cannot re-request here.
    assign req      = pass ? (axis_i_tvalid & ~grant_oh) : axis_i_tvalid;
    assign pkt_done = axis_o_tvalid & axis_o_tready & axis_o_tlast;

    rr_priority_select #(
        .NumReq (NUM_INPUTS)
    ) u_select (
        .req_i   (req),
        .last_i  (grant_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        sel           = int'(grant_q);
        axis_o_tdata  = axis_i_tdata[sel*DataW +: DataW];
        axis_o_tuser  = axis_i_tuser[sel*AXIS_USER_BITS +: AXIS_USER_BITS];
        axis_o_tlast  = axis_i_tlast[grant_q];
        axis_o_tvalid = pass & axis_i_tvalid[grant_q];
        axis_i_tready = pass ? (grant_oh & {NUM_INPUTS{axis_o_tready}}) : '0;
    end

`ifdef AXIS_PACKET_ARBITER_ID_EN
    assign axis_o_id = grant_q;
`endif

    // Reset grant to the last index so the first search after reset begins at source 0.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            grant_q <= IdxW'(NUM_INPUTS - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        state_q <= StPass;
                    end
                end
                StPass: begin
                    if (pkt_done) begin
                        if (pick_valid) begin
                            grant_q <= pick_idx;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
